baud_tx_ce: RTL and testbench
=============================

BAUD_TX_CE -- requirements
Module: baud_tx_ce

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter PARITY_EN, default 0, 1 = append parity bit.
REQ-003 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have port HF_Ck, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port Rs_N, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port HF_CE, input, 1, global clock enable; when low, no state changes.
REQ-008 SHALL have port Bit_CE, input, 1, one-cycle bit-rate strobe from the fractional NCO divider's LF_CE_O.
REQ-009 SHALL have port Tx_Data, input, DATA_W, word to send.
REQ-010 SHALL have port Tx_Valid, input, 1, Tx_Data valid.
REQ-011 SHALL have port Tx_Ready, output, 1, holding register empty.
REQ-012 SHALL have port Tx_O, output, 1, serial line, idle high.
REQ-013 SHALL have port Busy_O, output, 1, frame in progress or holding register full.

Function
REQ-014 SHALL accept a word on an edge where Rs_N=1, HF_CE=1, Tx_Valid=1 and Tx_Ready=1; the word goes into a one-entry holding register.
REQ-015 Tx_Ready SHALL be registered, low while the holding register is full, and independent of Tx_Valid in the same cycle.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions only on edges with HF_CE=1 and Bit_CE=1.
REQ-017 IDLE->START on Bit_CE when holding full: move the word into the shift register, free the holding register, drive Tx_O=0 from that edge.
REQ-018 START->DATA on next Bit_CE; DATA SHALL shift LSB first, one bit per Bit_CE interval, for exactly DATA_W intervals.
REQ-019 DATA->PARITY when PARITY_EN=1, else DATA->STOP; parity bit = XOR of data bits, inverted when PARITY_ODD=1.
REQ-020 STOP SHALL drive Tx_O=1 for STOP_BITS Bit_CE intervals.
REQ-021 At the final stop-bit Bit_CE: holding full -> START on the same edge (no idle gap); else -> IDLE.
REQ-022 A holding-register accept and a holding->shifter transfer on the same edge SHALL both take effect; the new word stays held and Tx_Ready goes low.
REQ-023 Tx_O SHALL be registered: each bit starts on the edge after the Bit_CE sample that selects it and lasts until the next Bit_CE.
REQ-024 Bit_CE with HF_CE=0 SHALL be ignored; Tx_Valid with HF_CE=0 SHALL NOT be accepted.
REQ-025 Busy_O SHALL equal (state != IDLE) OR holding full, registered.
REQ-026 Parameters SHALL be static; no run-time frame-format change.

Reset
REQ-027 On an edge with Rs_N=0 the block SHALL enter IDLE, clear the holding register, and set Tx_O=1, Tx_Ready=1, Busy_O=0, regardless of HF_CE.
REQ-028 Reset mid-frame SHALL abort the frame; Tx_O returns high on that edge and the held word is discarded.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE, START, DATA, PARITY, STOP) and frame-length constants derived from the parameters.
REQ-030 Bit counter width SHALL be clog2(DATA_W+1); no sub-modules; pairs with the NCO divider at the parent level (LF_CE_O -> Bit_CE).

Verification (Bit_CE every 4 cycles, HF_CE=1 unless stated)
REQ-031 DATA_W=8, no parity, 1 stop, send 0x55 -> Tx_O = 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles, then idle high; Busy_O falls after stop.
REQ-032 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> data 1,1,1,0,0,0,0,0, parity 1, stop 1; with PARITY_ODD=1 parity = 0.
REQ-033 Tx_Valid held high with 0xA1, 0xB2, 0xC3 -> first accepted at once, second accepted when first moves to shifter, third stalls (Tx_Ready=0) until second starts; frames back-to-back with no idle bit.
REQ-034 STOP_BITS=2, send 0xFF -> stop high for 8 cycles before next start bit.
REQ-035 HF_CE=0 for 10 cycles mid-DATA -> Tx_O frozen, no Bit_CE counted; bit sequence resumes intact when HF_CE=1.
REQ-036 Rs_N=0 for one cycle during DATA with a word held -> next edge Tx_O=1, Tx_Ready=1, Busy_O=0; no further frame emitted.

Source files
------------

// File: rtl/baud_tx_ce_pkg.sv
// -----------------------------------------------------------------------------
// baud_tx_ce_pkg
// Shared definitions for the baud_tx_ce serial transmitter:
//   - tx_state_e   : frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   - DEF_*        : default frame-format parameters
//   - bit_cnt_width: width of the per-field bit counter for a given word size
//   - frame_bits   : total line bits per frame for a given frame format
// No ports; import with "import baud_tx_ce_pkg::*;".
// -----------------------------------------------------------------------------
package baud_tx_ce_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
  localparam int DEF_STOP_BITS  = 1;

  // The same counter tracks data bits (up to data_w) and stop bits (up to 2),
  // so it only has to be wide enough to hold data_w itself.
  function automatic int bit_cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int frame_bits(input int data_w, input int parity_en,
                                    input int stop_bits);
    return 1 + data_w + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/baud_tx_ce.sv
// -----------------------------------------------------------------------------
// baud_tx_ce
// Asynchronous-serial (UART style) transmitter paced by an external bit-rate
// strobe. A one-entry holding register decouples the producer from the shift
// register so consecutive frames go out back-to-back with no idle bit.
//
// Parameters
//   DATA_W     : data bits per frame (5..9)
//   PARITY_EN  : 1 = append a parity bit after the data bits
//   PARITY_ODD : 1 = odd parity, 0 = even parity
//   STOP_BITS  : stop bits per frame (1 or 2)
//
// Ports
//   HF_Ck    in   single clock, everything on its rising edge
//   Rs_N     in   synchronous active-low reset (wins over HF_CE)
//   HF_CE    in   global clock enable; low freezes all state
//   Bit_CE   in   one-cycle bit-rate strobe (from the NCO divider's LF_CE_O)
//   Tx_Data  in   word to send
//   Tx_Valid in   Tx_Data valid
//   Tx_Ready out  holding register empty (registered)
//   Tx_O     out  serial line, idle high (registered)
//   Busy_O   out  frame in progress or holding register full (registered)
// -----------------------------------------------------------------------------
module baud_tx_ce
  import baud_tx_ce_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic              HF_Ck,
  input  logic              Rs_N,
  input  logic              HF_CE,
  input  logic              Bit_CE,
  input  logic [DATA_W-1:0] Tx_Data,
  input  logic              Tx_Valid,
  output logic              Tx_Ready,
  output logic              Tx_O,
  output logic              Busy_O
);

  localparam int CNT_W = bit_cnt_width(DATA_W);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS);
  localparam logic             ODD_INV   = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic tick;
  logic accept;
  logic load;

  assign tick   = HF_CE & Bit_CE;
  assign accept = HF_CE & Tx_Valid & ready_q;

  // Next-state logic. The sequencer only moves on an enabled bit strobe; the
  // holding register can fill on any enabled cycle. Every line bit is decided
  // here and registered, so Tx_O changes on the strobe edge that selects it.
  // The count tracks bits already put on the line within the current field:
  // START emits data bit 0 and sets it to 1, so DATA leaves once it reaches
  // DATA_W; entering STOP sets it to 1 for the first stop bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    load        = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            load = 1'b1;
          end
        end

        START: begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = CNT_ONE;
        end

        DATA: begin
          if (cnt_q == LAST_DATA) begin
            if (HAS_PAR) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
              cnt_d   = CNT_ONE;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end

        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = CNT_ONE;
        end

        STOP: begin
          if (cnt_q == LAST_STOP) begin
            // Chain straight into the next frame when a word is waiting.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    // Holding register -> shifter. Parity is computed on the whole word up
    // front so the PARITY state only has to replay a stored bit.
    if (load) begin
      state_d  = START;
      shift_d  = hold_q;
      parity_d = (^hold_q) ^ ODD_INV;
      tx_d     = 1'b0;
      cnt_d    = '0;
    end

    // A transfer and a new accept on the same edge both take effect: the
    // old word leaves for the shifter and the new one stays held.
    if (accept) begin
      hold_d = Tx_Data;
    end
    hold_full_d = (hold_full_q & ~load) | accept;

    ready_d = ~hold_full_d;
    busy_d  = (state_d != IDLE) | hold_full_d;
  end

  // All state is registered here. Reset is synchronous and overrides HF_CE;
  // a frame in flight is abandoned and any held word dropped.
  always_ff @(posedge HF_Ck) begin
    if (!Rs_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else if (HF_CE) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign Tx_Ready = ready_q;
  assign Tx_O     = tx_q;
  assign Busy_O   = busy_q;

endmodule

// File: tb/tb_baud_tx_ce.sv
// -----------------------------------------------------------------------------
// tb_baud_tx_ce
// Drives five baud_tx_ce instances with different frame formats from shared
// inputs. Each accepted word is expanded into the list of line bits it must
// produce (start, data LSB first, optional parity, stop bits); the monitor
// plays those bits out one per enabled bit strobe and compares the line,
// Tx_Ready and Busy_O of every instance on every clock.
// -----------------------------------------------------------------------------
module tb_baud_tx_ce;

  localparam int NI = 5;
  localparam int CFG_W    [NI] = '{8, 8, 5, 9, 8};
  localparam int CFG_PAR  [NI] = '{0, 1, 1, 1, 1};
  localparam int CFG_ODD  [NI] = '{0, 0, 1, 1, 1};
  localparam int CFG_STOP [NI] = '{1, 2, 1, 2, 1};

  logic          HF_Ck;
  logic          Rs_N;
  logic          HF_CE;
  logic          Bit_CE;
  logic          Tx_Valid;
  logic [8:0]    tx_data;
  logic [NI-1:0] tx_o;
  logic [NI-1:0] tx_ready;
  logic [NI-1:0] busy;

  int tests;
  int failed;

  logic rand_bce;
  int   div_cnt;

  // Expected line behaviour per instance.
  logic       m_level    [NI];
  logic       m_held     [NI];
  logic       m_in_frame [NI];
  logic [8:0] m_word     [NI];
  logic       fb         [NI][16];
  int         fb_len     [NI];
  int         fb_ptr     [NI];

  logic       s_rs, s_ce, s_bce, s_v;
  logic [8:0] s_d;
  logic       was_ready;

  baud_tx_ce #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .HF_Ck(HF_Ck), .Rs_N(Rs_N), .HF_CE(HF_CE), .Bit_CE(Bit_CE),
    .Tx_Data(tx_data[7:0]), .Tx_Valid(Tx_Valid),
    .Tx_Ready(tx_ready[0]), .Tx_O(tx_o[0]), .Busy_O(busy[0]));

  baud_tx_ce #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .HF_Ck(HF_Ck), .Rs_N(Rs_N), .HF_CE(HF_CE), .Bit_CE(Bit_CE),
    .Tx_Data(tx_data[7:0]), .Tx_Valid(Tx_Valid),
    .Tx_Ready(tx_ready[1]), .Tx_O(tx_o[1]), .Busy_O(busy[1]));

  baud_tx_ce #(.DATA_W(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .HF_Ck(HF_Ck), .Rs_N(Rs_N), .HF_CE(HF_CE), .Bit_CE(Bit_CE),
    .Tx_Data(tx_data[4:0]), .Tx_Valid(Tx_Valid),
    .Tx_Ready(tx_ready[2]), .Tx_O(tx_o[2]), .Busy_O(busy[2]));

  baud_tx_ce #(.DATA_W(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut3 (
    .HF_Ck(HF_Ck), .Rs_N(Rs_N), .HF_CE(HF_CE), .Bit_CE(Bit_CE),
    .Tx_Data(tx_data[8:0]), .Tx_Valid(Tx_Valid),
    .Tx_Ready(tx_ready[3]), .Tx_O(tx_o[3]), .Busy_O(busy[3]));

  baud_tx_ce #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut4 (
    .HF_Ck(HF_Ck), .Rs_N(Rs_N), .HF_CE(HF_CE), .Bit_CE(Bit_CE),
    .Tx_Data(tx_data[7:0]), .Tx_Valid(Tx_Valid),
    .Tx_Ready(tx_ready[4]), .Tx_O(tx_o[4]), .Busy_O(busy[4]));

  initial begin
    HF_Ck = 1'b0;
    forever #5 HF_Ck = ~HF_Ck;
  end

  // Bit-rate strobe: one pulse every 4 clocks, or random pulses when asked.
  initial begin
    div_cnt = 0;
    Bit_CE  = 1'b0;
    forever begin
      @(negedge HF_Ck);
      if (rand_bce) begin
        Bit_CE = ($urandom_range(0, 2) == 0);
      end else begin
        Bit_CE  = (div_cnt == 3);
        div_cnt = (div_cnt + 1) % 4;
      end
    end
  end

  // Line bits a word must produce on instance i.
  task automatic build_frame(input int i, input logic [8:0] w);
    int   n;
    logic p;
    p = 1'b0;
    fb[i][0] = 1'b0;
    for (int k = 0; k < CFG_W[i]; k++) begin
      fb[i][1 + k] = w[k];
      p = p ^ w[k];
    end
    n = 1 + CFG_W[i];
    if (CFG_PAR[i] != 0) begin
      fb[i][n] = p ^ (CFG_ODD[i] != 0);
      n = n + 1;
    end
    for (int s = 0; s < CFG_STOP[i]; s++) begin
      fb[i][n] = 1'b1;
      n = n + 1;
    end
    fb_len[i] = n;
    fb_ptr[i] = 0;
  endtask

  task automatic checkOutput(input string name, input int inst,
                             input logic act, input logic exp);
    tests = tests + 1;
    if (act !== exp) begin
      failed = failed + 1;
      $display("[TB] FAIL %s inst%0d at %0t: got %b, expected %b",
               name, inst, $time, act, exp);
    end
  endtask

  // Monitor: advance the expected line on each enabled strobe, record
  // accepted words, then compare all outputs just after the edge.
  always begin
    @(posedge HF_Ck);
    s_rs  = Rs_N;
    s_ce  = HF_CE;
    s_bce = Bit_CE;
    s_v   = Tx_Valid;
    s_d   = tx_data;
    for (int i = 0; i < NI; i++) begin
      if (!s_rs) begin
        m_held[i]     = 1'b0;
        m_in_frame[i] = 1'b0;
        m_level[i]    = 1'b1;
        fb_len[i]     = 0;
        fb_ptr[i]     = 0;
      end else if (s_ce) begin
        was_ready = !m_held[i];
        if (s_bce) begin
          if (fb_ptr[i] < fb_len[i]) begin
            m_level[i] = fb[i][fb_ptr[i]];
            fb_ptr[i]  = fb_ptr[i] + 1;
          end else if (m_held[i]) begin
            build_frame(i, m_word[i]);
            m_held[i]     = 1'b0;
            m_level[i]    = fb[i][0];
            fb_ptr[i]     = 1;
            m_in_frame[i] = 1'b1;
          end else begin
            m_level[i]    = 1'b1;
            m_in_frame[i] = 1'b0;
            fb_len[i]     = 0;
            fb_ptr[i]     = 0;
          end
        end
        if (s_v && was_ready) begin
          m_held[i] = 1'b1;
          m_word[i] = s_d;
        end
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("tx_o", i, tx_o[i], m_level[i]);
      checkOutput("tx_ready", i, tx_ready[i], !m_held[i]);
      checkOutput("busy", i, busy[i], m_in_frame[i] || m_held[i]);
    end
  end

  task automatic applyStimulus(input logic rs, input logic ce, input logic v,
                               input logic [8:0] d, input int n);
    Rs_N     = rs;
    HF_CE    = ce;
    Tx_Valid = v;
    tx_data  = d;
    repeat (n) @(negedge HF_Ck);
  endtask

  task automatic sendWord(input logic [8:0] w, input int gap);
    applyStimulus(1'b1, 1'b1, 1'b1, w, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, w, gap);
  endtask

  logic [8:0] words [3];
  logic       r;
  int         guard;

  initial begin
    tests    = 0;
    failed   = 0;
    rand_bce = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_level[i]    = 1'b1;
      m_held[i]     = 1'b0;
      m_in_frame[i] = 1'b0;
      m_word[i]     = '0;
      fb_len[i]     = 0;
      fb_ptr[i]     = 0;
    end
    words[0] = 9'h0A1;
    words[1] = 9'h0B2;
    words[2] = 9'h0C3;

    applyStimulus(1'b0, 1'b0, 1'b0, 9'h000, 3);
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, 6);

    sendWord(9'h055, 64);
    sendWord(9'h007, 64);
    sendWord(9'h0FF, 64);

    // Tx_Valid held high; step to the next word each time dut0 takes one.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, words[k], 0);
      guard = 0;
      do begin
        r = tx_ready[0];
        @(negedge HF_Ck);
        guard = guard + 1;
      end while (!r && guard < 200);
      if (!r) begin
        tests  = tests + 1;
        failed = failed + 1;
        $display("[TB] FAIL accept_timeout word%0d: got no accept, expected accept within 200 cycles", k);
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, 200);

    // Clock enable dropped for 10 cycles in the middle of the data bits.
    sendWord(9'h03C, 14);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000, 10);
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, 70);

    // Reset during data bits with a second word waiting.
    sendWord(9'h05A, 8);
    sendWord(9'h066, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, 70);

    // Random traffic, random strobes, occasional enable drop or reset.
    rand_bce = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 2) == 0),
                    9'($urandom_range(0, 511)), 1);
    end
    rand_bce = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, 250);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
